// File: rtl/fpnew_pkg.sv
// Shared FPU types used by blocks around the FPU top level.
package fpnew_pkg;

   // IEEE 754 exception flags reported with every result.
   typedef struct packed {
      logic NV;
      logic DZ;
      logic OF;
      logic UF;
      logic NX;
   } status_t;

endpackage

// File: rtl/fpnew_reorder_buffer.sv
// In-order completion buffer: tags FPU operations with a sequence ID at issue,
// captures out-of-order results and releases them in allocation order.
module fpnew_reorder_buffer
   import fpnew_pkg::*;
#(
   parameter int unsigned Width   = 64,
   parameter int unsigned Depth   = 4,
   parameter type         TagType = logic,
   localparam int unsigned IdWidth = $clog2(Depth)
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               flush_i,
   input  logic               alloc_valid_i,
   output logic               alloc_ready_o,
   input  TagType             alloc_tag_i,
   output logic [IdWidth-1:0] alloc_id_o,
   input  logic               cmpl_valid_i,
   output logic               cmpl_ready_o,
   input  logic [IdWidth-1:0] cmpl_id_i,
   input  logic [Width-1:0]   cmpl_result_i,
   input  status_t            cmpl_status_i,
   output logic               out_valid_o,
   input  logic               out_ready_i,
   output logic [Width-1:0]   result_o,
   output status_t            status_o,
   output TagType             tag_o,
   output logic               empty_o,
   output logic               full_o
);

   localparam int unsigned PtrWidth = IdWidth + 1;

   typedef struct packed {
      logic [Width-1:0] result;
      status_t          status;
      TagType           tag;
   } entry_t;

   logic [PtrWidth-1:0] head_q, head_d;
   logic [PtrWidth-1:0] tail_q, tail_d;
   logic [Depth-1:0]    alloc_q, alloc_d;
   logic [Depth-1:0]    done_q, done_d;
   entry_t              mem_q [Depth];
   entry_t              mem_d [Depth];

   logic [IdWidth-1:0]  head_idx;
   logic [IdWidth-1:0]  tail_idx;
   logic                alloc_fire;
   logic                retire_fire;
   logic                cmpl_accept;

   assign head_idx = head_q[IdWidth-1:0];
   assign tail_idx = tail_q[IdWidth-1:0];

   // Wrap bit distinguishes full from empty when the index bits match.
   assign full_o  = (head_idx == tail_idx) && (head_q[IdWidth] != tail_q[IdWidth]);
   assign empty_o = (head_q == tail_q);

   assign alloc_ready_o = ~full_o;
   assign alloc_id_o    = tail_idx;
   assign cmpl_ready_o  = 1'b1;

   assign out_valid_o = alloc_q[head_idx] & done_q[head_idx];
   assign result_o    = mem_q[head_idx].result;
   assign status_o    = mem_q[head_idx].status;
   assign tag_o       = mem_q[head_idx].tag;

   assign alloc_fire  = alloc_valid_i & alloc_ready_o;
   assign retire_fire = out_valid_o & out_ready_i;
   assign cmpl_accept = cmpl_valid_i & alloc_q[cmpl_id_i] & ~done_q[cmpl_id_i];

   // Allocate, complete and retire always target distinct entries, so their
   // updates compose; flush discards all of them.
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      alloc_d = alloc_q;
      done_d  = done_q;
      mem_d   = mem_q;

      if (flush_i) begin
         head_d  = '0;
         tail_d  = '0;
         alloc_d = '0;
         done_d  = '0;
      end else begin
         if (alloc_fire) begin
            alloc_d[tail_idx]   = 1'b1;
            done_d[tail_idx]    = 1'b0;
            mem_d[tail_idx].tag = alloc_tag_i;
            tail_d              = tail_q + PtrWidth'(1);
         end
         if (cmpl_accept) begin
            done_d[cmpl_id_i]       = 1'b1;
            mem_d[cmpl_id_i].result = cmpl_result_i;
            mem_d[cmpl_id_i].status = cmpl_status_i;
         end
         if (retire_fire) begin
            alloc_d[head_idx] = 1'b0;
            done_d[head_idx]  = 1'b0;
            head_d            = head_q + PtrWidth'(1);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         head_q  <= '0;
         tail_q  <= '0;
         alloc_q <= '0;
         done_q  <= '0;
         for (int i = 0; i < int'(Depth); i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         alloc_q <= alloc_d;
         done_q  <= done_d;
         mem_q   <= mem_d;
      end
   end

endmodule

// File: tb/tb_fpnew_reorder_buffer.sv
// Bench for fpnew_reorder_buffer: directed scenarios plus randomized traffic,
// checked every cycle against a queue model held in allocation order.
module tb_fpnew_reorder_buffer;
   import fpnew_pkg::*;

   localparam int DEPTH = 4;
   localparam int IDW   = 2;

   logic            clk_i = 1'b0;
   logic            rst_ni = 1'b0;
   logic            flush_i = 1'b0;
   logic            alloc_valid_i = 1'b0;
   logic            alloc_ready_o;
   logic [7:0]      alloc_tag_i = '0;
   logic [IDW-1:0]  alloc_id_o;
   logic            cmpl_valid_i = 1'b0;
   logic            cmpl_ready_o;
   logic [IDW-1:0]  cmpl_id_i = '0;
   logic [63:0]     cmpl_result_i = '0;
   status_t         cmpl_status_i = '0;
   logic            out_valid_o;
   logic            out_ready_i = 1'b0;
   logic [63:0]     result_o;
   status_t         status_o;
   logic [7:0]      tag_o;
   logic            empty_o;
   logic            full_o;

   fpnew_reorder_buffer #(
      .Width   (64),
      .Depth   (DEPTH),
      .TagType (logic [7:0])
   ) dut (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .flush_i       (flush_i),
      .alloc_valid_i (alloc_valid_i),
      .alloc_ready_o (alloc_ready_o),
      .alloc_tag_i   (alloc_tag_i),
      .alloc_id_o    (alloc_id_o),
      .cmpl_valid_i  (cmpl_valid_i),
      .cmpl_ready_o  (cmpl_ready_o),
      .cmpl_id_i     (cmpl_id_i),
      .cmpl_result_i (cmpl_result_i),
      .cmpl_status_i (cmpl_status_i),
      .out_valid_o   (out_valid_o),
      .out_ready_i   (out_ready_i),
      .result_o      (result_o),
      .status_o      (status_o),
      .tag_o         (tag_o),
      .empty_o       (empty_o),
      .full_o        (full_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [IDW-1:0] id;
      logic [7:0]     tag;
      bit             done;
      logic [63:0]    res;
      logic [4:0]     st;
   } ent_t;

   ent_t q[$];
   int   tail_cnt = 0;
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Expected outputs derived from the in-order queue of in-flight operations.
   task automatic compare_model();
      bit exp_valid;
      exp_valid = (q.size() > 0) && q[0].done;
      chk("out_valid", 64'(out_valid_o), 64'(exp_valid));
      chk("alloc_ready", 64'(alloc_ready_o), 64'(q.size() < DEPTH));
      chk("full", 64'(full_o), 64'(q.size() == DEPTH));
      chk("empty", 64'(empty_o), 64'(q.size() == 0));
      chk("alloc_id", 64'(alloc_id_o), 64'(tail_cnt % DEPTH));
      chk("cmpl_ready", 64'(cmpl_ready_o), 64'd1);
      if (exp_valid) begin
         chk("result", result_o, q[0].res);
         chk("status", 64'(status_o), 64'(q[0].st));
         chk("tag", 64'(tag_o), 64'(q[0].tag));
      end
   endtask

   // One clock: drive at negedge, advance model at posedge, compare at next negedge.
   task automatic step(input bit av, input logic [7:0] tg, input bit cv, input logic [IDW-1:0] cid,
                       input logic [63:0] res, input logic [4:0] st, input bit ordy, input bit fl);
      bit do_alloc;
      bit do_retire;
      int hit;
      alloc_valid_i = av;
      alloc_tag_i   = tg;
      cmpl_valid_i  = cv;
      cmpl_id_i     = cid;
      cmpl_result_i = res;
      cmpl_status_i = status_t'(st);
      out_ready_i   = ordy;
      flush_i       = fl;
      do_alloc  = av && (q.size() < DEPTH);
      do_retire = ordy && (q.size() > 0) && q[0].done;
      hit = -1;
      if (cv) begin
         foreach (q[i]) if (q[i].id == cid && !q[i].done) hit = i;
         if (hit < 0) begin
            errors++;
            $display("FAIL cmpl_target: id %0d is not an outstanding entry", cid);
         end
      end
      @(posedge clk_i);
      if (fl) begin
         q.delete();
         tail_cnt = 0;
      end else begin
         if (hit >= 0) begin
            q[hit].done = 1'b1;
            q[hit].res  = res;
            q[hit].st   = st;
         end
         if (do_retire) void'(q.pop_front());
         if (do_alloc) begin
            q.push_back('{id: IDW'(tail_cnt % DEPTH), tag: tg, done: 1'b0, res: '0, st: '0});
            tail_cnt = (tail_cnt + 1) % (2 * DEPTH);
         end
      end
      @(negedge clk_i);
      alloc_valid_i = 1'b0;
      cmpl_valid_i  = 1'b0;
      flush_i       = 1'b0;
      compare_model();
   endtask

   task automatic idle(input bit ordy);
      step(1'b0, 8'h0, 1'b0, '0, 64'h0, 5'h0, ordy, 1'b0);
   endtask

   initial begin
      int pend[$];
      int pick;
      // Reset state.
      @(negedge clk_i);
      chk("rst_empty", 64'(empty_o), 64'd1);
      chk("rst_full", 64'(full_o), 64'd0);
      chk("rst_alloc_ready", 64'(alloc_ready_o), 64'd1);
      chk("rst_out_valid", 64'(out_valid_o), 64'd0);
      chk("rst_alloc_id", 64'(alloc_id_o), 64'd0);
      chk("rst_result", result_o, 64'd0);
      chk("rst_status", 64'(status_o), 64'd0);
      chk("rst_tag", 64'(tag_o), 64'd0);
      rst_ni = 1'b1;
      @(negedge clk_i);
      compare_model();

      // Three allocations, completed out of order 2,0,1.
      chk("id0", 64'(alloc_id_o), 64'd0);
      step(1'b1, 8'hA, 1'b0, '0, 64'h0, 5'h0, 1'b0, 1'b0);
      chk("id1", 64'(alloc_id_o), 64'd1);
      step(1'b1, 8'hB, 1'b0, '0, 64'h0, 5'h0, 1'b0, 1'b0);
      chk("id2", 64'(alloc_id_o), 64'd2);
      step(1'b1, 8'hC, 1'b0, '0, 64'h0, 5'h0, 1'b0, 1'b0);
      chk("three_full", 64'(full_o), 64'd0);
      chk("three_valid", 64'(out_valid_o), 64'd0);
      step(1'b0, 8'h0, 1'b1, 2'd2, 64'h22, 5'h0, 1'b1, 1'b0);
      chk("held_id2", 64'(out_valid_o), 64'd0);
      step(1'b0, 8'h0, 1'b1, 2'd0, 64'h00, 5'h0, 1'b0, 1'b0);
      chk("ret0_valid", 64'(out_valid_o), 64'd1);
      chk("ret0_tag", 64'(tag_o), 64'hA);
      chk("ret0_res", result_o, 64'h00);
      step(1'b0, 8'h0, 1'b1, 2'd1, 64'h11, 5'h0, 1'b1, 1'b0);
      chk("ret1_tag", 64'(tag_o), 64'hB);
      chk("ret1_res", result_o, 64'h11);
      idle(1'b1);
      chk("ret2_tag", 64'(tag_o), 64'hC);
      chk("ret2_res", result_o, 64'h22);
      idle(1'b1);
      chk("drained", 64'(empty_o), 64'd1);

      // Fill from a zeroed pointer, then retire one with a blocked allocation.
      step(1'b0, 8'h0, 1'b0, '0, 64'h0, 5'h0, 1'b0, 1'b1);
      for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(8'h10 + i), 1'b0, '0, 64'h0, 5'h0, 1'b0, 1'b0);
      chk("fill_full", 64'(full_o), 64'd1);
      chk("fill_ready", 64'(alloc_ready_o), 64'd0);
      step(1'b1, 8'hEE, 1'b1, 2'd0, 64'h99, 5'h0, 1'b0, 1'b0);
      step(1'b1, 8'hEE, 1'b0, '0, 64'h0, 5'h0, 1'b1, 1'b0);
      chk("after_retire_ready", 64'(alloc_ready_o), 64'd1);
      chk("wrap_id", 64'(alloc_id_o), 64'd0);

      // Stall with head done and NV set.
      step(1'b0, 8'h0, 1'b1, 2'd1, 64'h55, 5'b10000, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         chk("stall_valid", 64'(out_valid_o), 64'd1);
         chk("stall_res", result_o, 64'h55);
         chk("stall_nv", 64'(status_o.NV), 64'd1);
         idle(1'b0);
      end
      idle(1'b1);
      chk("stall_accepted", 64'(out_valid_o), 64'd0);

      // Three in flight, one done, flush with concurrent alloc and completion.
      step(1'b1, 8'h77, 1'b1, 2'd3, 64'h33, 5'h1, 1'b0, 1'b0);
      step(1'b1, 8'h78, 1'b1, 2'd2, 64'h44, 5'h0, 1'b1, 1'b1);
      chk("flush_empty", 64'(empty_o), 64'd1);
      chk("flush_valid", 64'(out_valid_o), 64'd0);
      chk("flush_id", 64'(alloc_id_o), 64'd0);

      // Randomized traffic with a mid-run asynchronous reset.
      for (int n = 0; n < 3000; n++) begin
         pend.delete();
         foreach (q[i]) if (!q[i].done) pend.push_back(i);
         pick = (pend.size() > 0 && ($urandom % 4 != 0)) ? pend[$urandom % pend.size()] : -1;
         step(1'($urandom), 8'($urandom),
              pick >= 0, (pick >= 0) ? q[pick].id : '0,
              {32'($urandom), 32'($urandom)}, 5'($urandom),
              ($urandom % 10) < 7, ($urandom % 64) == 0);
         if (n == 1500) begin
            if (q.size() == 0) step(1'b1, 8'h5A, 1'b0, '0, 64'h0, 5'h0, 1'b0, 1'b0);
            rst_ni = 1'b0;
            #1;
            chk("arst_empty", 64'(empty_o), 64'd1);
            chk("arst_full", 64'(full_o), 64'd0);
            chk("arst_valid", 64'(out_valid_o), 64'd0);
            chk("arst_ready", 64'(alloc_ready_o), 64'd1);
            chk("arst_id", 64'(alloc_id_o), 64'd0);
            chk("arst_result", result_o, 64'd0);
            q.delete();
            tail_cnt = 0;
            @(negedge clk_i);
            rst_ni = 1'b1;
            compare_model();
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
